uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `UartTx` transmitter between `NUM_REQ` byte producers. It sits directly in front of the transmitter and owns its `TxDataInput`/`TxEnable` inputs. It issues exactly one byte per transmitter idle period and watches `TxReady` to sequence the frames. An optional packet-lock mode keeps the transmitter with one requester until that requester's last byte has gone out.

---
 rtl/uart_tx_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that shares one UART transmitter between NUM_REQ byte
// producers. It owns the transmitter's data/enable inputs and issues exactly
// one byte per transmitter idle period. It sequences frames by watching
// TxReady fall (frame started) and rise again (frame done).
//
// Optional feature (compile-time macro UART_TX_ARB_LOCK_EN):
//   packet lock. A byte acked with ReqLast=0 keeps the transmitter with the
//   same requester until it sends a byte with ReqLast=1, or until a busy
//   timeout. With the macro undefined, ReqLast is ignored and every byte is
//   arbitrated on its own.
//
// Parameters:
//   NUM_REQ       number of requesters (2..8)
//   GRANT_W       width of GrantId, equal to clog2(NUM_REQ)
//   BUSY_TIMEOUT  cycles allowed after issue for TxReady to fall (2..255)
//
// Ports:
//   Clk           clock shared with the transmitter
//   Reset         asynchronous active-low reset
//   ReqValid      per-requester byte pending
//   ReqData       requester i byte on [8i+7:8i]
//   ReqLast       pending byte ends a packet (lock mode only)
//   ReqAck        one-hot, one-cycle "byte consumed" pulse
//   TxDataOutput  byte to the transmitter, held between issues
//   TxEnable      one-cycle issue pulse to the transmitter
//   TxReady       transmitter idle
//   GrantId       last or current granted requester
//   Busy          high in every state except ARB
//   TimeoutErr    one-cycle pulse when TxReady failed to fall in time
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GRANT_W      = 2,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NUM_REQ-1:0]     ReqValid,
    input  logic [8*NUM_REQ-1:0]   ReqData,
    input  logic [NUM_REQ-1:0]     ReqLast,
    output logic [NUM_REQ-1:0]     ReqAck,
    output logic [7:0]             TxDataOutput,
    output logic                   TxEnable,
    input  logic                   TxReady,
    output logic [GRANT_W-1:0]     GrantId,
    output logic                   Busy,
    output logic                   TimeoutErr
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    // Registered state and outputs
    state_e              state_q,  state_d;
    logic [GRANT_W-1:0]  grant_q,  grant_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic                tx_en_q,  tx_en_d;
    logic [NUM_REQ-1:0]  ack_q,    ack_d;
    logic                busy_q,   busy_d;
    logic                tmo_q,    tmo_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                lock_q,   lock_d;

    // Arbitration helpers
    logic [NUM_REQ-1:0]  lock_mask_c;
    logic [NUM_REQ-1:0]  elig_c;
    logic                found_c;
    logic [GRANT_W-1:0]  winner_c;
    logic [GRANT_W-1:0]  cand_c;
    logic [NUM_REQ-1:0]  win_onehot_c;
    logic [DATA_W-1:0]   win_data_c;
    logic                win_last_c;
    logic [CNT_W-1:0]    cnt_inc_c;

`ifndef UART_TX_ARB_LOCK_EN
    // Packet boundaries are irrelevant without the lock.
    logic unused_last_c;
    assign unused_last_c = ^ReqLast;
`endif

    // Eligible requesters: all valid ones, or only the holder while locked.
    always_comb begin
        lock_mask_c          = '0;
        lock_mask_c[grant_q] = 1'b1;
        elig_c               = ReqValid;
        if (lock_q) begin
            elig_c = ReqValid & lock_mask_c;
        end
    end

    // Circular search starting one past the previous grant.
    always_comb begin
        found_c  = 1'b0;
        winner_c = grant_q;
        cand_c   = grant_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_c = GRANT_W'((32'(grant_q) + k) % NUM_REQ);
            if (!found_c && elig_c[cand_c]) begin
                found_c  = 1'b1;
                winner_c = cand_c;
            end
        end
    end

    // Winner's byte, packet-end flag and ack pattern.
    always_comb begin
        win_data_c             = '0;
        win_last_c             = 1'b1;
        win_onehot_c           = '0;
        win_onehot_c[winner_c] = 1'b1;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner_c == GRANT_W'(i)) begin
                win_data_c = ReqData[8*i +: 8];
                win_last_c = ReqLast[i];
            end
        end
    end

    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        tx_en_d = 1'b0;
        ack_d   = '0;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;
        lock_d  = lock_q;

        case (state_q)
            ST_ARB: begin
                // Issue only into an idle transmitter.
                if (TxReady && found_c) begin
                    state_d = ST_ISSUE;
                    grant_d = winner_c;
                    data_d  = win_data_c;
                    tx_en_d = 1'b1;
                    ack_d   = win_onehot_c;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d  = !win_last_c;
`endif
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end

            ST_WAIT_BUSY: begin
                if (!TxReady) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc_c;
                    // Transmitter never started: drop the byte and move on.
                    if (cnt_inc_c == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        state_d = ST_ARB;
                        tmo_d   = 1'b1;
                        lock_d  = 1'b0;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (TxReady) begin
                    state_d = ST_ARB;
                end
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase

        busy_d = (state_d != ST_ARB);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_ARB;
            grant_q <= GRANT_W'(NUM_REQ - 1);
            data_q  <= '0;
            tx_en_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            tx_en_q <= tx_en_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end

    assign ReqAck       = ack_q;
    assign TxDataOutput = data_q;
    assign TxEnable     = tx_en_q;
    assign GrantId      = grant_q;
    assign Busy         = busy_q;
    assign TimeoutErr   = tmo_q;

`ifndef SYNTHESIS
    // Issue only into an idle transmitter.
    a_en_needs_ready: assert property (@(posedge Clk) disable iff (!Reset)
        TxEnable |-> TxReady);

    // Ack accompanies the issue pulse and names a single requester.
    a_ack_with_en: assert property (@(posedge Clk) disable iff (!Reset)
        (ReqAck != '0) == TxEnable);

    a_ack_onehot: assert property (@(posedge Clk) disable iff (!Reset)
        $onehot0(ReqAck));
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned GRANT_W      = 2;
    localparam int unsigned BUSY_TIMEOUT = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct {
        int unsigned id;
        logic [7:0]  data;
    } exp_t;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic [NUM_REQ-1:0]   ReqValid;
    logic [8*NUM_REQ-1:0] ReqData;
    logic [NUM_REQ-1:0]   ReqLast;
    logic [NUM_REQ-1:0]   ReqAck;
    logic [7:0]           TxDataOutput;
    logic                 TxEnable;
    logic                 TxReady;
    logic [GRANT_W-1:0]   GrantId;
    logic                 Busy;
    logic                 TimeoutErr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    byte_t       ld_q  [NUM_REQ][$];
    byte_t       drv_q [NUM_REQ][$];
    exp_t        exp_q [$];
    int unsigned issue_log [$];

    // Reference model state
    int unsigned m_grant;
    bit          m_locked;
    logic [7:0]  m_last_data;

    // Transmitter model state
    bit          stuck = 1'b0;
    int unsigned pend = 0;
    int unsigned busy_left = 0;

    bit          tmo_pend = 1'b0;
    int unsigned tmo_cyc = 0;
    int unsigned tmo_seen = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .GRANT_W      (GRANT_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqData      (ReqData),
        .ReqLast      (ReqLast),
        .ReqAck       (ReqAck),
        .TxDataOutput (TxDataOutput),
        .TxEnable     (TxEnable),
        .TxReady      (TxReady),
        .GrantId      (GrantId),
        .Busy         (Busy),
        .TimeoutErr   (TimeoutErr)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void add(int unsigned r, logic [7:0] d, logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        ld_q[r].push_back(b);
    endfunction

    // Hand the loaded bytes to the requesters and predict the issue order:
    // plain round robin over the pending queues, honouring packet lock.
    function automatic void launch();
        byte_t       mq [NUM_REQ][$];
        int unsigned remaining;
        int unsigned w;
        int unsigned c;
        exp_t        e;
        remaining = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mq[i] = ld_q[i];
            remaining += mq[i].size();
            foreach (ld_q[i][j]) drv_q[i].push_back(ld_q[i][j]);
            ld_q[i].delete();
        end
        while (remaining > 0) begin
            w = NUM_REQ;
            if (m_locked) begin
                if (mq[m_grant].size() > 0) w = m_grant;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_grant + k) % NUM_REQ;
                    if (w == NUM_REQ && mq[c].size() > 0) w = c;
                end
            end
            if (w == NUM_REQ) break;
            e.id   = w;
            e.data = mq[w][0].data;
            exp_q.push_back(e);
            m_last_data = mq[w][0].data;
            m_grant     = w;
`ifdef UART_TX_ARB_LOCK_EN
            m_locked = !stuck && !mq[w][0].last;
`else
            m_locked = 1'b0;
`endif
            mq[w].delete(0);
            remaining--;
        end
    endfunction

    // Requesters: present the head byte, advance on ack.
    initial begin
        ReqValid = '0;
        ReqData  = '0;
        ReqLast  = '0;
        forever begin
            @(posedge Clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ReqAck[i] && drv_q[i].size() > 0) drv_q[i].delete(0);
                if (drv_q[i].size() > 0) begin
                    ReqValid[i]       = 1'b1;
                    ReqData[8*i +: 8] = drv_q[i][0].data;
                    ReqLast[i]        = drv_q[i][0].last;
                end else begin
                    ReqValid[i] = 1'b0;
                    ReqLast[i]  = 1'b0;
                end
            end
        end
    end

    // Transmitter: drops TxReady 1..3 cycles after TxEnable, frame of 2..8 cycles.
    initial begin
        TxReady = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            if (!Reset) begin
                TxReady   = 1'b1;
                busy_left = 0;
                pend      = 0;
            end else begin
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) TxReady = 1'b1;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        TxReady   = 1'b0;
                        busy_left = $urandom_range(2, 8);
                    end
                end
                if (TxEnable) begin
                    check("issue_into_idle_tx",
                          32'((busy_left > 0) || (pend > 0) || !TxReady), 32'd0);
                    if (!stuck) pend = $urandom_range(1, 3);
                end
            end
        end
    end

    // Monitor: compare every issue against the scoreboard, and timeout pulses.
    initial begin
        exp_t e;
        logic tmo_exp;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                if (TxEnable) begin
                    issue_log.push_back(32'(GrantId));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_issue: got grant %0d data 0x%0h, required no issue",
                                 GrantId, TxDataOutput);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_id", 32'(GrantId), e.id);
                        check("tx_data", 32'(TxDataOutput), 32'(e.data));
                        check("req_ack", 32'(ReqAck), 32'd1 << e.id);
                        if (stuck) begin
                            tmo_pend = 1'b1;
                            tmo_cyc  = cyc + BUSY_TIMEOUT;
                        end
                    end
                end else if (ReqAck != '0) begin
                    check("ack_without_issue", 32'(ReqAck), 32'd0);
                end
                tmo_exp = tmo_pend && (cyc == tmo_cyc);
                if (TimeoutErr || tmo_exp) begin
                    check("timeout_err", 32'(TimeoutErr), 32'(tmo_exp));
                    if (TimeoutErr) tmo_seen++;
                    tmo_pend = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int unsigned n;
        bit          done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge Clk);
            n++;
            done = (exp_q.size() == 0) && TxReady && !Busy && (ReqValid == '0)
                   && (pend == 0) && (busy_left == 0) && !tmo_pend;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle: got %0d issues outstanding after %0d cycles, required 0",
                     tag, exp_q.size(), n);
            exp_q.delete();
        end else begin
            check({tag, "_data_hold"}, 32'(TxDataOutput), 32'(m_last_data));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_enable"}, 32'(TxEnable), 32'd0);
        check({tag, "_req_ack"}, 32'(ReqAck), 32'd0);
        check({tag, "_tx_data"}, 32'(TxDataOutput), 32'd0);
        check({tag, "_timeout"}, 32'(TimeoutErr), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_grant"}, 32'(GrantId), NUM_REQ - 1);
    endtask

    task automatic check_log(input string tag, input int unsigned ref_ids[$]);
        check({tag, "_count"}, issue_log.size(), ref_ids.size());
        foreach (ref_ids[i]) begin
            if (i < issue_log.size()) check({tag, "_order"}, issue_log[i], ref_ids[i]);
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned len;
        byte_t       b;
        int unsigned lock_ref [$];

        Reset = 1'b0;
        m_grant     = NUM_REQ - 1;
        m_locked    = 1'b0;
        m_last_data = 8'h00;
        repeat (3) @(negedge Clk);
        check_reset_outputs("rst");
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // Single byte from requester 0: issue one cycle after the request.
        add(0, 8'hA5, 1'b1);
        launch();
        @(posedge Clk);
        #2;
        check("a5_no_early_issue", 32'(TxEnable), 32'd0);
        @(posedge Clk);
        #2;
        check("a5_tx_enable", 32'(TxEnable), 32'd1);
        check("a5_tx_data", 32'(TxDataOutput), 32'h0000_00A5);
        check("a5_req_ack", 32'(ReqAck), 32'b0001);
        n = 0;
        while (TxReady && n < 20) begin @(negedge Clk); n++; end
        while (!TxReady && n < 40) begin @(negedge Clk); n++; end
        check("a5_frame_seen", 32'(n < 40), 32'd1);
        check("a5_busy_in_wait_done", 32'(Busy), 32'd1);
        @(posedge Clk);
        #2;
        check("a5_busy_falls", 32'(Busy), 32'd0);
        wait_idle("a5");

        // Reset while the transmitter is mid-frame.
        add(1, 8'h3C, 1'b1);
        launch();
        n = 0;
        while (!(!TxReady && Busy) && n < 50) begin @(negedge Clk); n++; end
        check("mid_reset_reached_wait_done", 32'(n < 50), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) drv_q[i].delete();
        tmo_pend    = 1'b0;
        m_grant     = NUM_REQ - 1;
        m_locked    = 1'b0;
        m_last_data = 8'h00;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // All requesters continuously valid: strict rotation from requester 0.
        issue_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) add(i, 8'(8'h10 + i), 1'b1);
        launch();
        wait_idle("rotation");
        check_log("rotation", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Packet: requester 2 sends three bytes while requester 0 waits.
        add(1, 8'h77, 1'b1);
        launch();
        wait_idle("lock_pre");
        issue_log.delete();
        add(2, 8'h21, 1'b0);
        add(2, 8'h22, 1'b0);
        add(2, 8'h23, 1'b1);
        add(0, 8'h01, 1'b1);
        launch();
        wait_idle("lock");
`ifdef UART_TX_ARB_LOCK_EN
        lock_ref = '{2, 2, 2, 0};
`else
        lock_ref = '{2, 0, 2, 2};
`endif
        check_log("lock", lock_ref);

        // Transmitter stuck idle: each issue times out, next requester served.
        stuck    = 1'b1;
        tmo_seen = 0;
        issue_log.delete();
        add(1, 8'h55, 1'b0);
        add(2, 8'h66, 1'b1);
        launch();
        wait_idle("stuck");
        check("stuck_timeouts", tmo_seen, 32'd2);
        check("stuck_issues", issue_log.size(), 32'd2);
        stuck = 1'b0;

        // Randomized traffic.
        for (int ph = 0; ph < 10; ph++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                len = $urandom_range(0, 5);
                for (int j = 0; j < int'(len); j++) begin
                    b.data = 8'($urandom);
                    b.last = (j == int'(len) - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                    ld_q[i].push_back(b);
                end
            end
            launch();
            wait_idle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
